// File: rtl/keypad_digit_buffer.sv
// Multi-digit keypad entry register. Newest digit sits in the low slot, and a committed
// code is held for the downstream checker until it completes a valid/ready handshake.
module keypad_digit_buffer #(
  parameter int DIGITS    = 4,
  parameter int DIGIT_W   = 4,
  parameter bit OVERWRITE = 1'b1,
  localparam int CW = $clog2(DIGITS + 1),
  localparam int BW = DIGITS * DIGIT_W
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [DIGIT_W-1:0] NewValue,
  input  logic               Enable,
  input  logic               Backspace,
  input  logic               Clear,
  input  logic               Commit,
  output logic [BW-1:0]      ShiftedValues,
  output logic [CW-1:0]      Count,
  output logic               Empty,
  output logic               Full,
  output logic [BW-1:0]      CommitData,
  output logic [CW-1:0]      CommitCount,
  output logic               CommitValid,
  input  logic               CommitReady,
  output logic               Dropped
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ENTRY = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]    state, stateNext;
  logic [BW-1:0] shiftedNext, commitDataNext;
  logic [CW-1:0] countNext, commitCountNext;
  logic          commitValidNext, droppedNext;
  logic          isFull;

  assign isFull = (Count == CW'(DIGITS));

  // Only the highest-priority strobe acts; masked strobes never raise Dropped.
  always_comb begin
    stateNext       = state;
    shiftedNext     = ShiftedValues;
    countNext       = Count;
    commitDataNext  = CommitData;
    commitCountNext = CommitCount;
    commitValidNext = CommitValid;
    droppedNext     = 1'b0;
    if (state == HOLD) begin
      droppedNext = Enable | Commit;
      if (CommitValid && CommitReady) begin
        commitValidNext = 1'b0;
        stateNext       = IDLE;
      end
    end else begin
      if (Clear) begin
        shiftedNext = '0;
        countNext   = '0;
      end else if (Commit) begin
        if (Count != '0) begin
          commitDataNext  = ShiftedValues;
          commitCountNext = Count;
          commitValidNext = 1'b1;
          shiftedNext     = '0;
          countNext       = '0;
        end
      end else if (Backspace) begin
        if (Count != '0) begin
          shiftedNext = ShiftedValues >> DIGIT_W;
          countNext   = Count - CW'(1);
        end
      end else if (Enable) begin
        if (!isFull) begin
          shiftedNext = {ShiftedValues[BW-DIGIT_W-1:0], NewValue};
          countNext   = Count + CW'(1);
        end else begin
          droppedNext = 1'b1;
          if (OVERWRITE)
            shiftedNext = {ShiftedValues[BW-DIGIT_W-1:0], NewValue};
        end
      end
      if (commitValidNext)
        stateNext = HOLD;
      else if (countNext == '0)
        stateNext = IDLE;
      else
        stateNext = ENTRY;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= IDLE;
      ShiftedValues <= '0;
      Count         <= '0;
      Empty         <= 1'b1;
      Full          <= 1'b0;
      CommitData    <= '0;
      CommitCount   <= '0;
      CommitValid   <= 1'b0;
      Dropped       <= 1'b0;
    end else begin
      state         <= stateNext;
      ShiftedValues <= shiftedNext;
      Count         <= countNext;
      Empty         <= (countNext == '0);
      Full          <= (countNext == CW'(DIGITS));
      CommitData    <= commitDataNext;
      CommitCount   <= commitCountNext;
      CommitValid   <= commitValidNext;
      Dropped       <= droppedNext;
    end
  end

endmodule
